red_pitaya_pwm_dac: RTL and testbench

//  Converts one 24-bit PWM DAC word from the analog mixed-signal register block into a single-bit PWM stream.

---
 rtl/red_pitaya_pwm_pkg.sv | 25 ++
 rtl/red_pitaya_pwm_dac.sv | 92 +++++++++
 tb/tb_red_pitaya_pwm_dac.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants, the DAC word type and the duty helper for the PWM DAC channels.
package red_pitaya_pwm_pkg;

   localparam int PWM_FULL_DEF = 156;
   localparam int PWM_CW_DEF   = 8;

   localparam int CFG_DUTY_MSB = 23;
   localparam int CFG_DUTY_LSB = 16;
   localparam int CFG_DITH_W   = 16;
   localparam int FRAME_LEN    = 16;

   localparam int CFG_W  = CFG_DUTY_MSB + 1;
   localparam int DUTY_W = CFG_DUTY_MSB - CFG_DUTY_LSB + 2;
   localparam int BCNT_W = $clog2(FRAME_LEN);

   typedef logic [CFG_W-1:0] pwm_cfg_t;

   // Coarse duty plus the dither bit selected by the period index, 9 bits so it never overflows.
   function automatic logic [DUTY_W-1:0] pwm_duty(input pwm_cfg_t w, input logic [BCNT_W-1:0] k);
      logic [CFG_DITH_W-1:0] dith;
      dith = w[CFG_DITH_W-1:0];
      return {1'b0, w[CFG_DUTY_MSB:CFG_DUTY_LSB]} + {{(DUTY_W-1){1'b0}}, dith[k]};
   endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac.sv
// Single-channel dithered PWM DAC: a 24-bit word latched once per 16-period frame.
// Optional macro PWM_DAC_SYNC_EN adds sync_i to restart the period/frame for phase alignment.
module red_pitaya_pwm_dac
   import red_pitaya_pwm_pkg::*;
#(
   parameter int FULL = PWM_FULL_DEF,
   parameter int CW   = PWM_CW_DEF
)(
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [CFG_W-1:0] cfg_i,
`ifdef PWM_DAC_SYNC_EN
   input  logic             sync_i,
`endif
   output logic             pwm_o,
   output logic             frame_o
);

   localparam logic [CW-1:0]     VCNT_LAST = CW'(FULL - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_LEN - 1);
   localparam int                DW        = (CW + 1 > DUTY_W) ? CW + 1 : DUTY_W;

   logic [CW-1:0]     vcnt_r;
   logic [CW-1:0]     vcnt_nxt_s;
   logic [BCNT_W-1:0] bcnt_r;
   logic [BCNT_W-1:0] bcnt_nxt_s;
   pwm_cfg_t          b_r;
   pwm_cfg_t          b_nxt_s;
   logic [DUTY_W-1:0] duty_s;
   logic              pwm_nxt_s;
   logic              frame_nxt_s;
   logic              sync_s;

`ifdef PWM_DAC_SYNC_EN
   assign sync_s = sync_i;
`else
   assign sync_s = 1'b0;
`endif

   // Next-state: sync restart outranks counter wrap; the word is only taken at a frame boundary.
   always_comb begin
      duty_s      = pwm_duty(b_r, bcnt_r);
      vcnt_nxt_s  = vcnt_r;
      bcnt_nxt_s  = bcnt_r;
      b_nxt_s     = b_r;
      pwm_nxt_s   = 1'b0;
      frame_nxt_s = 1'b0;
      if (sync_s) begin
         vcnt_nxt_s  = VCNT_LAST;
         bcnt_nxt_s  = BCNT_LAST;
         b_nxt_s     = b_r;
         pwm_nxt_s   = 1'b0;
         frame_nxt_s = 1'b0;
      end else begin
         // The compare uses the pre-edge word, so the old word still drives the latching edge.
         pwm_nxt_s = (DW'(vcnt_r) < DW'(duty_s));
         if (vcnt_r == VCNT_LAST) begin
            vcnt_nxt_s = {CW{1'b0}};
            bcnt_nxt_s = bcnt_r + BCNT_W'(1'b1);
            if (bcnt_r == BCNT_LAST) begin
               b_nxt_s     = cfg_i;
               frame_nxt_s = 1'b1;
            end else begin
               b_nxt_s     = b_r;
               frame_nxt_s = 1'b0;
            end
         end else begin
            vcnt_nxt_s  = vcnt_r + CW'(1'b1);
            bcnt_nxt_s  = bcnt_r;
            frame_nxt_s = 1'b0;
         end
      end
   end

   // State and output registers; reset parks the counters so the first edge is a frame boundary.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vcnt_r  <= VCNT_LAST;
         bcnt_r  <= BCNT_LAST;
         b_r     <= {CFG_W{1'b0}};
         pwm_o   <= 1'b0;
         frame_o <= 1'b0;
      end else begin
         vcnt_r  <= vcnt_nxt_s;
         bcnt_r  <= bcnt_nxt_s;
         b_r     <= b_nxt_s;
         pwm_o   <= pwm_nxt_s;
         frame_o <= frame_nxt_s;
      end
   end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Directed bench for red_pitaya_pwm_dac: per-period and per-frame high counts against hand-computed values.
module tb_red_pitaya_pwm_dac;

   localparam int FULL  = 156;
   localparam int FRAME = 16 * FULL;

   logic        clk_i;
   logic        rstn_i;
   logic [23:0] cfg_i;
   logic        pwm_o;
   logic        frame_o;
   int          n_checks;
   int          n_errors;
   int          highs;
   int          frames;
   int          h1;
   int          f1;

`ifdef PWM_DAC_SYNC_EN
   logic sync_i;
   logic rstn2_i;
   logic pwm2_o;
   logic frame2_o;

   red_pitaya_pwm_dac dut2 (
      .clk_i   (clk_i),
      .rstn_i  (rstn2_i),
      .cfg_i   (cfg_i),
      .sync_i  (sync_i),
      .pwm_o   (pwm2_o),
      .frame_o (frame2_o)
   );
`endif

   red_pitaya_pwm_dac dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .cfg_i   (cfg_i),
`ifdef PWM_DAC_SYNC_EN
      .sync_i  (sync_i),
`endif
      .pwm_o   (pwm_o),
      .frame_o (frame_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance n edges, sampling on the falling edge after each.
   task automatic run(input int n, output int hi, output int fr);
      hi = 0;
      fr = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (pwm_o === 1'b1) hi++;
         if (frame_o === 1'b1) fr++;
      end
   endtask

   // Reset with cfg applied, release on a falling edge, check reset values.
   task automatic do_reset(input logic [23:0] cfg);
      @(negedge clk_i);
      rstn_i = 1'b0;
      cfg_i  = cfg;
      #1;
      check("reset_pwm", int'(pwm_o), 0);
      check("reset_frame", int'(frame_o), 0);
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   // Reset release with a 15-cycle duty: frame pulse in cycle 1, 15 high per period.
   task automatic test_basic(input string tag);
      int hi;
      int fr;
      do_reset(24'h0F_0000);
      run(1, hi, fr);
      check({tag, "_first_pwm"}, hi, 0);
      check({tag, "_first_frame"}, fr, 1);
      run(FULL, hi, fr);
      check({tag, "_p0_high"}, hi, 15);
      run(FULL, hi, fr);
      check({tag, "_p1_high"}, hi, 15);
      run(FRAME - 2 * FULL, hi, fr);
      check({tag, "_rest_high"}, hi, 14 * 15);
      check({tag, "_rest_frame"}, fr, 1);
   endtask

   // One full frame (edges 2..2497 after release) high count for a given word.
   task automatic frame_high(input logic [23:0] cfg, input string tag, input int exp);
      int hi;
      int fr;
      do_reset(cfg);
      run(1, hi, fr);
      run(FRAME, hi, fr);
      check(tag, hi, exp);
      check({tag, "_frame"}, fr, 1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rstn_i   = 1'b0;
      cfg_i    = 24'h00_0000;
`ifdef PWM_DAC_SYNC_EN
      sync_i  = 1'b0;
      rstn2_i = 1'b0;
`endif
      repeat (3) @(negedge clk_i);

      test_basic("basic");

      // Dither bit 0: period 0 gets 79, the others 78.
      do_reset(24'h4E_0001);
      run(1, highs, frames);
      run(FULL, highs, frames);
      check("dith_p0", highs, 79);
      run(FULL, highs, frames);
      check("dith_p1", highs, 78);
      run(FRAME - 2 * FULL, highs, frames);
      check("dith_rest", highs, 14 * 78);
      check("dith_frame_len", frames, 1);

      frame_high(24'h00_0000, "zero_duty", 0);
      frame_high(24'h9B_FFFF, "sat_dith", FRAME);
      frame_high(24'hFF_0000, "sat_coarse", FRAME);
      frame_high(24'h10_A5A5, "mean_a5a5", 16 * 16 + 8);

      // Mid-frame word change is ignored until the next frame boundary.
      do_reset(24'h75_0000);
      run(1, highs, frames);
      run(999, h1, f1);
      cfg_i = 24'h9C_0000;
      run(FRAME - 999, highs, frames);
      check("midchg_old_high", highs + h1, 16 * 117);
      check("midchg_frames", frames + f1, 1);
      run(FRAME, highs, frames);
      check("midchg_new_high", highs, FRAME);

      // Asynchronous reset in the middle of a high phase.
      do_reset(24'h9B_FFFF);
      run(500, highs, frames);
      check("pre_rst_pwm", int'(pwm_o), 1);
      #2;
      rstn_i = 1'b0;
      #1;
      check("async_rst_pwm", int'(pwm_o), 0);
      test_basic("after_rst");

`ifdef PWM_DAC_SYNC_EN
      begin
         int diff;
         rstn_i  = 1'b0;
         rstn2_i = 1'b0;
         cfg_i   = 24'h4E_00F3;
         @(negedge clk_i);
         rstn_i = 1'b1;
         repeat (37) @(negedge clk_i);
         rstn2_i = 1'b1;
         repeat (300) @(negedge clk_i);
         sync_i = 1'b1;
         repeat (3) @(negedge clk_i);
         sync_i = 1'b0;
         diff   = 0;
         highs  = 0;
         frames = 0;
         for (int i = 0; i < FRAME + 10; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (pwm_o !== pwm2_o || frame_o !== frame2_o) diff++;
            if (frame_o === 1'b1) frames++;
            if (pwm_o === 1'b1) highs++;
         end
         check("sync_align_diff", diff, 0);
         check("sync_frames", frames, 2);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
